// File: rtl/instr_encoder_loader_pkg.sv
// Shared opcode, instruction-type and FSM encodings for the loader and main_decoder.
package instr_encoder_loader_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        T_LOAD   = 2'b00,
        T_STORE  = 2'b01,
        T_RTYPE  = 2'b10,
        T_BRANCH = 2'b11
    } itype_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    typedef struct packed {
        itype_e      ty;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        sub;
        logic [12:0] imm;
    } fields_t;

    // Misaligned branch target, or a load/R-type whose result would go to x0.
    function automatic logic illegal(input fields_t f);
        return (f.ty == T_BRANCH && f.imm[0]) ||
               ((f.ty == T_LOAD || f.ty == T_RTYPE) && f.rd == 5'd0);
    endfunction

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// instr_pack: packs instruction type and fields into a 32-bit RV32I word (purely combinational).
module instr_pack
    import instr_encoder_loader_pkg::*;
(
    input  fields_t     f_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = '0;
        case (f_i.ty)
            T_LOAD:   word_o = {f_i.imm[11:0], f_i.rs1, f_i.f3, f_i.rd, OP_LOAD};
            T_STORE:  word_o = {f_i.imm[11:5], f_i.rs2, f_i.rs1, f_i.f3, f_i.imm[4:0], OP_STORE};
            T_RTYPE:  word_o = {1'b0, f_i.sub, 5'b00000, f_i.rs2, f_i.rs1, f_i.f3, f_i.rd, OP_RTYPE};
            T_BRANCH: word_o = {f_i.imm[12], f_i.imm[10:5], f_i.rs2, f_i.rs1, f_i.f3,
                                f_i.imm[4:1], f_i.imm[11], OP_BRANCH};
            default:  word_o = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams instruction-field beats into instruction memory, one encoded word per beat.
// Define ENC_CHECK_EN to drop illegal beats and flag them on err.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_type,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_sub,
    input  logic [12:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic              overflow,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0] BASE_P = (ADDR_W + 1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] ONE_P  = (ADDR_W + 1)'(1);

    state_e            state_q, state_d;
    // Next write address; the extra MSB marks the memory as exhausted.
    logic [ADDR_W:0]   ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              we_q, ovf_q;
    fields_t           fields;
    logic [31:0]       word;
    logic              accept, bad, wr, hit_cap, fin;

    assign fields = '{ty: itype_e'(in_type), rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                      f3: in_funct3, sub: in_sub, imm: in_imm};

    instr_pack u_pack (
        .f_i    (fields),
        .word_o (word)
    );

`ifdef ENC_CHECK_EN
    logic err_q;
    assign bad = illegal(fields);
    assign err = err_q;
`else
    assign bad = 1'b0;
    assign err = 1'b0;
`endif

    assign accept  = in_valid && in_ready;
    assign wr      = accept && !bad;
    assign hit_cap = wr && (&ptr_q[ADDR_W-1:0]) && !in_last;
    assign fin     = accept && (in_last || hit_cap);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (fin)   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_RUN) && !ptr_q[ADDR_W];
        done     = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= BASE_P;
            count_q <= '0;
            addr_q  <= BASE_P[ADDR_W-1:0];
            wdata_q <= '0;
            we_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            we_q <= wr;
            if (state_q == S_IDLE && start) begin
                ptr_q   <= BASE_P;
                count_q <= '0;
                addr_q  <= BASE_P[ADDR_W-1:0];
                ovf_q   <= 1'b0;
            end
            if (wr) begin
                addr_q  <= ptr_q[ADDR_W-1:0];
                wdata_q <= word;
                ptr_q   <= ptr_q + ONE_P;
                count_q <= count_q + ONE_P;
            end
            if (hit_cap) ovf_q <= 1'b1;
        end
    end

`ifdef ENC_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)                            err_q <= 1'b0;
        else if (state_q == S_IDLE && start) err_q <= 1'b0;
        else if (accept && bad)             err_q <= 1'b1;
    end
`endif

    // Reset kills a write already registered for this cycle.
    assign imem_we    = we_q && !rst;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign overflow   = ovf_q;
    assign word_count = count_q;

endmodule
